// File: rtl/rr_request_agent.sv
// rr_request_agent
// Requester-side companion to a round-robin arbiter. Job pulses from N_REQ clients
// go into a saturating pending count per client. Every client with work pending
// raises a level request to the arbiter. The agent takes the arbiter's one-hot
// grant, serves the granted client for HOLD_CYCLES cycles, then spends one RELEASE
// cycle that pulses done_o to that client and retires one of its pending jobs.
//
// Ports
//   clk             rising-edge clock
//   rst_i           synchronous active-high reset
//   req_pulse_i     one-cycle job pulse per client
//   grants_i        one-hot grant from the arbiter (zero = no grant)
//   reqs_o          level requests to the arbiter
//   busy_o          a client owns the bus (SERVE or RELEASE)
//   owner_o         index of the current or most recent owner
//   done_o          one-cycle completion pulse to the owner
//   overflow_o      sticky, per client: a pulse was dropped at a saturated count
//   proto_err_o     sticky: an illegal grant was seen in ARB
//   pending_total_o sum of all pending counts
module rr_request_agent #(
  parameter int N_REQ       = 8,
  parameter int CNT_W       = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_pulse_i,
  input  logic [N_REQ-1:0]               grants_i,
  output logic [N_REQ-1:0]               reqs_o,
  output logic                           busy_o,
  output logic [$clog2(N_REQ)-1:0]       owner_o,
  output logic [N_REQ-1:0]               done_o,
  output logic [N_REQ-1:0]               overflow_o,
  output logic                           proto_err_o,
  output logic [$clog2(N_REQ)+CNT_W-1:0] pending_total_o
);

  localparam int OW = $clog2(N_REQ);
  localparam int TW = $clog2(N_REQ) + CNT_W;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]  pend_q [N_REQ];
  logic [CNT_W-1:0]  pend_d [N_REQ];
  logic [N_REQ-1:0]  overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;

  logic [N_REQ-1:0]  nz_s;
  logic              grant_onehot_s;
  logic              grant_accept_s;
  logic [OW-1:0]     grant_idx_s;

  // State register: FSM, owner, hold counter, pending counts and sticky flags.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= ST_ARB;
      owner_q     <= '0;
      hold_q      <= '0;
      overflow_q  <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) pend_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      for (int i = 0; i < N_REQ; i++) pend_q[i] <= pend_d[i];
    end
  end

  // Grant decode: a grant counts only if it is one-hot and targets a client with work.
  always_comb begin
    grant_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      nz_s[i] = (pend_q[i] != '0);
      if (grants_i[i]) begin
        grant_idx_s = OW'(i);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    grant_onehot_s = (grants_i != '0) && ((grants_i & (grants_i - 1'b1)) == '0);
    grant_accept_s = grant_onehot_s && ((grants_i & nz_s) != '0);
  end

  // Next-state logic: FSM transitions, owner capture, hold countdown, protocol errors.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    proto_err_d = proto_err_q;
    case (state_q)
      ST_ARB: begin
        if (grant_accept_s) begin
          owner_d = grant_idx_s;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = ST_SERVE;
        end else if (grants_i != '0) begin
          proto_err_d = 1'b1;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_SERVE: begin
        if (hold_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      ST_RELEASE: state_d = ST_ARB;
      default:    state_d = ST_ARB;
    endcase
  end

  // Pending counters: a simultaneous pulse and retire cancel out; pulses at max are dropped.
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < N_REQ; i++) begin
      logic inc, dec;
      inc = req_pulse_i[i];
      dec = (state_q == ST_RELEASE) && (owner_q == OW'(i));
      pend_d[i] = pend_q[i];
      if (inc && !dec) begin
        if (pend_q[i] == CNT_MAX) begin
          overflow_d[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + CNT_W'(1);
        end
      end else if (dec && !inc) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Outputs depend only on registered state, so the arbiter's combinational grant
  // cannot close a loop back through reqs_o.
  always_comb begin
    reqs_o          = '0;
    done_o          = '0;
    busy_o          = 1'b0;
    pending_total_o = '0;
    case (state_q)
      ST_ARB:     reqs_o = nz_s;
      ST_SERVE:   busy_o = 1'b1;
      ST_RELEASE: begin
        busy_o          = 1'b1;
        done_o[owner_q] = 1'b1;
      end
      default:    busy_o = 1'b0;
    endcase
    for (int i = 0; i < N_REQ; i++) begin
      pending_total_o = pending_total_o + TW'(pend_q[i]);
    end
    owner_o     = owner_q;
    overflow_o  = overflow_q;
    proto_err_o = proto_err_q;
  end

endmodule
